// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard detector. Each register has countdown counters: cycles until
// write-back and cycles until its result can be forwarded.
module scoreboard_hazard_unit #(
  parameter int REG_COUNT    = 16,
  parameter int REG_ADDR_W   = 4,
  parameter int WB_LAT       = 2,
  parameter int ALU_FWD_LAT  = 0,
  parameter int LOAD_FWD_LAT = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issueValid,
  input  logic [REG_ADDR_W-1:0]  src1,
  input  logic [REG_ADDR_W-1:0]  src2,
  input  logic                   twoSrc,
  input  logic [REG_ADDR_W-1:0]  destination,
  input  logic                   writeBackEn,
  input  logic                   memRead,
  input  logic                   forwardEn,
  input  logic                   freeze,
  input  logic                   flush,
  output logic                   hazardDetected,
  output logic [REG_COUNT-1:0]   busyMask,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam int CNT_W = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);

  logic [CNT_W-1:0]       r_wb_cnt  [REG_COUNT];
  logic [CNT_W-1:0]       r_fwd_cnt [REG_COUNT];
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic [REG_COUNT-1:0] w_src1_hit;
  logic [REG_COUNT-1:0] w_src2_hit;
  logic                 w_hazard;
  logic                 w_issue;
  logic [CNT_W-1:0]     w_fwd_init;

  assign w_hazard       = issueValid && !flush && ((|w_src1_hit) || (twoSrc && (|w_src2_hit)));
  assign hazardDetected = w_hazard;
  assign w_issue        = issueValid && !w_hazard && !flush && !freeze;
  assign w_fwd_init     = memRead ? CNT_W'(LOAD_FWD_LAT) : CNT_W'(ALU_FWD_LAT);
  assign stallCount     = r_stall_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_entry
      logic w_blocking;
      logic w_arm;

      // A busy entry blocks a reader unless forwarding is on and the value is already forwardable.
      assign w_blocking       = (r_wb_cnt[gi] != '0) && (!forwardEn || (r_fwd_cnt[gi] != '0));
      assign w_src1_hit[gi]   = (src1 == REG_ADDR_W'(gi)) && w_blocking;
      assign w_src2_hit[gi]   = (src2 == REG_ADDR_W'(gi)) && w_blocking;
      assign w_arm            = w_issue && writeBackEn && (destination == REG_ADDR_W'(gi));
      assign busyMask[gi]     = (r_wb_cnt[gi] != '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wb_cnt[gi]  <= '0;
          r_fwd_cnt[gi] <= '0;
        end else if (!freeze) begin
          if (w_arm) begin
            r_wb_cnt[gi]  <= CNT_W'(WB_LAT);
            r_fwd_cnt[gi] <= w_fwd_init;
          end else begin
            if (r_wb_cnt[gi] != '0) begin
              r_wb_cnt[gi] <= r_wb_cnt[gi] - CNT_W'(1);
            end
            if (r_fwd_cnt[gi] != '0) begin
              r_fwd_cnt[gi] <= r_fwd_cnt[gi] - CNT_W'(1);
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !freeze && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
